game_status_display: RTL



---
 rtl/game_disp_pkg.sv | 33 +++
 rtl/disp_seg_scan.sv | 49 ++++
 rtl/game_status_display.sv | 125 ++++++++++++
 3 files changed

// File: rtl/game_disp_pkg.sv
// Shared types and constants for the game status display.
//   disp_state_t : display state machine states
//   SEG_OFF      : all segments dark (active-low)
//   HEX7_TABLE   : active-low {a,b,c,d,e,f,g} patterns for hex digits 0-F
//   bar_pattern  : MSB-first health bar mask
package game_disp_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, WARN, OVER} disp_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Element n is the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    localparam int unsigned BAR_MAX_W = 64;

    // hp_c ones packed against bit led_w-1; caller truncates to its bar width.
    function automatic logic [BAR_MAX_W-1:0] bar_pattern(input int unsigned hp_c,
                                                         input int unsigned led_w);
        logic [BAR_MAX_W-1:0] mask;
        mask = '0;
        if (hp_c >= BAR_MAX_W) begin
            mask = '1;
        end else if (hp_c != 0) begin
            mask = ((BAR_MAX_W'(1) << hp_c) - BAR_MAX_W'(1)) << (led_w - hp_c);
        end
        return mask;
    endfunction

endpackage

// File: rtl/disp_seg_scan.sv
// Multiplexed 7-segment scan with a frame latch so digits never tear.
//   clk, rst_n : clock, synchronous active-low reset
//   score      : hex digits of the selected mode, digit 0 in the LSB nibble
//   frame_clr  : load zeros instead of score at the next frame boundary
//   blank      : force the display dark; counter and latch keep running
//   an, seg    : active-low digit enables and segments, registered together
module disp_seg_scan
    import game_disp_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*4-1:0]   score,
    input  logic                  frame_clr,
    input  logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int unsigned IDX_W = $clog2(DIGITS);

    logic [SCAN_DIV-1:0] cnt_q;
    logic [DIGITS*4-1:0] frame_q;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          nib;

    assign idx = cnt_q[SCAN_DIV-1 -: IDX_W];
    assign nib = frame_q[{idx, 2'b00} +: 4];

    // Counter, frame latch (loaded as the counter wraps), registered drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            frame_q <= '0;
            an      <= '1;
            seg     <= SEG_OFF;
        end else begin
            cnt_q <= cnt_q + SCAN_DIV'(1);
            if (&cnt_q) begin
                frame_q <= frame_clr ? '0 : score;
            end
            an  <= blank ? '1 : ~(DIGITS'(1) << idx);
            seg <= blank ? SEG_OFF : HEX7_TABLE[nib];
        end
    end

endmodule

// File: rtl/game_status_display.sv
// Status display controller: mode arbitration, health-bar LEDs with
// low-health blink and game-over flash, and the 7-segment score scan.
//   clk, rst_n  : clock, synchronous active-low reset
//   mode_en     : per-mode enable, lowest index wins
//   hp, score   : per-mode health and hex score digits
//   game_over   : game-over flag of the active mode
//   blank       : dark 7-segment display
//   led         : health bar / flash pattern
//   an, seg     : active-low digit enables and segments
//   active_mode : registered selected mode index
module game_status_display
    import game_disp_pkg::*;
#(
    parameter int unsigned NUM_MODES = 2,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned HP_W      = 5,
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 16,
    parameter int unsigned BLINK_DIV = 24,
    parameter int unsigned LOW_HP    = 4,
    localparam int unsigned SEL_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MODES-1:0]          mode_en,
    input  logic [NUM_MODES*HP_W-1:0]     hp,
    input  logic [NUM_MODES*DIGITS*4-1:0] score,
    input  logic                          game_over,
    input  logic                          blank,
    output logic [LED_W-1:0]              led,
    output logic [DIGITS-1:0]             an,
    output logic [6:0]                    seg,
    output logic [SEL_W-1:0]              active_mode
);

    disp_state_t           state_q;
    disp_state_t           ns;
    logic [SEL_W-1:0]      sel_nx;
    logic [HP_W-1:0]       hp_sel;
    logic [HP_W-1:0]       hp_c;
    logic [DIGITS*4-1:0]   score_sel;
    logic [BLINK_DIV-1:0]  blink_q;
    logic [LED_W-1:0]      bar;
    logic                  any_en;
    logic                  phase;

    // Lowest enabled index.
    always_comb begin
        sel_nx = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (mode_en[i]) sel_nx = SEL_W'(i);
        end
    end

    // Health and score of the registered selection.
    always_comb begin
        hp_sel    = '0;
        score_sel = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (SEL_W'(i) == active_mode) begin
                hp_sel    = hp[i*HP_W +: HP_W];
                score_sel = score[i*DIGITS*4 +: DIGITS*4];
            end
        end
    end

    assign any_en = |mode_en;
    assign hp_c   = (hp_sel > HP_W'(LED_W)) ? HP_W'(LED_W) : hp_sel;
    assign bar    = LED_W'(bar_pattern(32'(hp_c), LED_W));
    assign phase  = blink_q[BLINK_DIV-1];

    // Game over outranks the health rule; losing every enable wins over all.
    function automatic disp_state_t next_state(input disp_state_t cur,
                                               input logic en,
                                               input logic over,
                                               input logic hp_zero,
                                               input logic hp_low);
        disp_state_t nxt;
        nxt = PLAY;
        if (!en)                  nxt = IDLE;
        else if (cur == IDLE)     nxt = PLAY;
        else if (over || hp_zero) nxt = OVER;
        else if (hp_low)          nxt = WARN;
        else                      nxt = PLAY;
        return nxt;
    endfunction

    assign ns = next_state(state_q, any_en, game_over, hp_c == '0,
                           hp_c <= HP_W'(LOW_HP));

    // State, arbitration register, blink counter and LED drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_mode <= '0;
            blink_q     <= '0;
            led         <= '0;
        end else begin
            state_q     <= ns;
            active_mode <= sel_nx;
            blink_q     <= blink_q + BLINK_DIV'(1);
            case (ns)
                IDLE:    led <= '0;
                PLAY:    led <= bar;
                WARN:    led <= phase ? bar : '0;
                OVER:    led <= phase ? '1 : '0;
                default: led <= '0;
            endcase
        end
    end

    disp_seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .score     (score_sel),
        .frame_clr (state_q == IDLE),
        .blank     (blank),
        .an        (an),
        .seg       (seg)
    );

endmodule
